// File: rtl/sonar_scan_controller.sv
// Sonar scan controller: steps a servo through four positions, triggers a measurement after each
// move and publishes the result. Define SONAR_SCAN_TIMEOUT_EN to enable the measurement timeout.
module sonar_scan_controller #(
    parameter int SETTLE_CYCLES  = 25000000,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ligar,
    input  logic        pronto,
    input  logic [11:0] medida,
    output logic [1:0]  posicao,
    output logic        medir,
    output logic [11:0] medida_out,
    output logic [1:0]  posicao_out,
    output logic        valido,
    output logic        timeout,
    output logic        ocupado,
    output logic [3:0]  db_estado
);

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        POSICIONA = 4'd1,
        ESPERA    = 4'd2,
        MEDE      = 4'd3,
        AGUARDA   = 4'd4,
        ARMAZENA  = 4'd5,
        PROXIMO   = 4'd6
    } state_t;

    localparam int SETTLE_W = ($clog2(SETTLE_CYCLES) > 25) ? $clog2(SETTLE_CYCLES) : 25;

    state_t              state;
    state_t              state_next;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                settle_done;
    logic                timeout_hit;
    logic                dir_up;

    assign settle_done = (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= INICIAL;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            INICIAL:   if (ligar) state_next = POSICIONA;
            POSICIONA: state_next = ESPERA;
            ESPERA: begin
                if (!ligar)          state_next = INICIAL;
                else if (settle_done) state_next = MEDE;
            end
            MEDE:      state_next = AGUARDA;
            AGUARDA:   if (pronto || timeout_hit) state_next = ARMAZENA;
            ARMAZENA:  state_next = PROXIMO;
            PROXIMO:   state_next = ligar ? POSICIONA : INICIAL;
            default:   state_next = INICIAL;
        endcase
    end

    // Settle counter runs only while in ESPERA and is held at zero everywhere else.
    always_ff @(posedge clock) begin
        if (!reset || state != ESPERA) begin
            settle_cnt <= '0;
        end else if (!settle_done) begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

`ifdef SONAR_SCAN_TIMEOUT_EN
    localparam int TIMEOUT_W = ($clog2(TIMEOUT_CYCLES) > 22) ? $clog2(TIMEOUT_CYCLES) : 22;

    logic [TIMEOUT_W-1:0] timeout_cnt;
    logic                 timed_out;

    // Expiry fires on the TIMEOUT_CYCLES-th AGUARDA cycle; a pronto in that same cycle takes priority.
    assign timeout_hit = (state == AGUARDA) && (timeout_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (!reset || state != AGUARDA) begin
            timeout_cnt <= '0;
        end else if (!timeout_hit) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            posicao     <= 2'd0;
            dir_up      <= 1'b1;
            medida_out  <= 12'h000;
            posicao_out <= 2'd0;
`ifdef SONAR_SCAN_TIMEOUT_EN
            timed_out   <= 1'b0;
`endif
        end else begin
            if (state == AGUARDA && pronto) begin
                medida_out  <= medida;
                posicao_out <= posicao;
`ifdef SONAR_SCAN_TIMEOUT_EN
                timed_out   <= 1'b0;
            end else if (timeout_hit) begin
                medida_out  <= 12'hFFF;
                posicao_out <= posicao;
                timed_out   <= 1'b1;
`endif
            end
            // Triangle sweep 0..3..0; direction flips when an end position is reached.
            if (state == PROXIMO) begin
                if (dir_up) begin
                    posicao <= posicao + 2'd1;
                    if (posicao == 2'd2) dir_up <= 1'b0;
                end else begin
                    posicao <= posicao - 2'd1;
                    if (posicao == 2'd1) dir_up <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        medir     = (state == MEDE);
        valido    = (state == ARMAZENA);
        ocupado   = (state != INICIAL);
        db_estado = state;
`ifdef SONAR_SCAN_TIMEOUT_EN
        timeout   = (state == ARMAZENA) && timed_out;
`else
        timeout   = 1'b0;
`endif
    end

endmodule

// File: doc/sonar_scan_controller.md
SONAR_SCAN_CONTROLLER -- requirements
Module: sonar_scan_controller

Interface
REQ-001 Parameter SETTLE_CYCLES, default 25000000, is the number of clock cycles waited after each servo move before a measurement is triggered.
REQ-002 Parameter TIMEOUT_CYCLES, default 2500000, is the maximum number of cycles waited for pronto after medir is pulsed.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 clock  in  1  system clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 ligar  in  1  level; 1 = scanning enabled.
REQ-007 pronto  in  1  one-cycle pulse from the HC-SR04 interface when a measurement completes.
REQ-008 medida  in  12  BCD distance from the HC-SR04 interface, valid while pronto=1.
REQ-009 posicao  out  2  servo position command to the servo control module.
REQ-010 medir  out  1  one-cycle pulse that starts a measurement.
REQ-011 medida_out  out  12  last stored distance (BCD), or 12'hFFF on timeout.
REQ-012 posicao_out  out  2  position at which medida_out was taken.
REQ-013 valido  out  1  one-cycle pulse when medida_out/posicao_out are updated.
REQ-014 timeout  out  1  one-cycle pulse, concurrent with valido, when a measurement timed out.
REQ-015 ocupado  out  1  1 in every state except INICIAL.
REQ-016 db_estado  out  4  state code for the 7-seg debug display.

Function
REQ-017 FSM states and codes: INICIAL=0, POSICIONA=1, ESPERA=2, MEDE=3, AGUARDA=4, ARMAZENA=5, PROXIMO=6; all other codes go to INICIAL.
REQ-018 Transitions: INICIAL->POSICIONA when ligar=1; POSICIONA->ESPERA after 1 cycle; ESPERA->MEDE after exactly SETTLE_CYCLES cycles; MEDE->AGUARDA after 1 cycle; AGUARDA->ARMAZENA on pronto=1 or timeout; ARMAZENA->PROXIMO after 1 cycle; PROXIMO->POSICIONA if ligar=1, else INICIAL.
REQ-019 medir=1 only during the single MEDE cycle.
REQ-020 In ARMAZENA, valido=1 for one cycle; medida_out is the medida captured on the pronto cycle, and posicao_out is the current posicao.
REQ-021 posicao sweep order: 0,1,2,3,2,1,0,1,...; direction reverses at 0 and 3; posicao is updated only in PROXIMO.
REQ-022 If pronto is asserted in any state other than AGUARDA, it SHALL be ignored.
REQ-023 If ligar=0 during ESPERA, the FSM SHALL go to INICIAL on the next cycle without pulsing medir; posicao is held.
REQ-024 If ligar=0 during MEDE, AGUARDA or ARMAZENA, the current measurement SHALL complete and be stored; the FSM then exits from PROXIMO to INICIAL.
REQ-025 Counters: settle counter >= 25 bits and timeout counter >= 22 bits; both clear on entry to ESPERA and AGUARDA respectively; no wrap-around within one state.
REQ-026 If pronto and the timeout expiry occur in the same cycle, pronto SHALL win (real data stored, timeout=0).

Reset
REQ-027 While reset=0 at a rising clock edge, the following SHALL apply: state=INICIAL; posicao=0 with direction up; medir=0; medida_out=0; posicao_out=0; valido=0; timeout=0; ocupado=0; db_estado=0; all counters=0.
REQ-028 Reset asserted mid-operation (including AGUARDA) SHALL abort the cycle with no valido pulse; a pronto arriving afterwards SHALL be ignored.

Configuration
REQ-029 Macro SONAR_SCAN_TIMEOUT_EN: when defined, the AGUARDA timeout logic, the timeout output pulse and the 12'hFFF store SHALL be present.
REQ-030 When SONAR_SCAN_TIMEOUT_EN is undefined, AGUARDA SHALL wait for pronto indefinitely and timeout SHALL be tied to 0.

Verification (SETTLE_CYCLES=10, TIMEOUT_CYCLES=100, macro defined unless noted)
REQ-031 ligar=1 with pronto returned 20 cycles after medir and medida=12'h123 -> medir occurs 12 cycles after ligar; then valido=1, medida_out=12'h123 and posicao_out=0; the next posicao is 1.
REQ-032 Eight consecutive measurements -> posicao_out sequence 0,1,2,3,2,1,0,1.
REQ-033 pronto never returned -> 100 cycles after medir, valido=1, timeout=1 and medida_out=12'hFFF; the scan continues.
REQ-034 pronto on the exact timeout cycle -> the real medida is stored and timeout=0; with the macro undefined and no pronto for 1000 cycles, the FSM stays in AGUARDA (db_estado=4).
REQ-035 ligar dropped in ESPERA -> no medir pulse and INICIAL next cycle; ligar dropped in AGUARDA -> one valido pulse, then INICIAL.
REQ-036 reset=0 in AGUARDA followed by a late pronto -> all outputs at their reset values and no valido pulse.
